// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for the MIPS_32 core: loader > data > fetch, with a fetch starvation guard.
// Define MEM_ARB_STATS_EN to build the saturating contention counter on conflict_cnt.
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SRC_IF, SRC_DM, SRC_LD} src_t;

    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [1:0]      LAT_TOP    = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    src_t          src_q, src_d;
    logic [1:0]    lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic el_ld, el_dm, el_if, any_el, if_wins;
    src_t grant_src;

    assign el_ld   = ld_req & halted;
    assign el_dm   = dm_req;
    assign el_if   = if_req;
    assign any_el  = el_ld | el_dm | el_if;
    // A starved fetch overtakes data traffic, but never the loader.
    assign if_wins   = el_if & (~el_dm | (starve_q == STARVE_TOP));
    assign grant_src = el_ld ? SRC_LD : (if_wins ? SRC_IF : SRC_DM);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d     = state_q;
        src_d       = src_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (any_el) begin
                    src_d    = grant_src;
                    mem_en_d = 1'b1;
                    lat_d    = '0;
                    state_d  = ACCESS;
                    case (grant_src)
                        SRC_LD: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ld_addr;
                            mem_wdata_d = ld_wdata;
                        end
                        SRC_DM: begin
                            mem_we_d    = dm_we;
                            mem_addr_d  = dm_addr;
                            mem_wdata_d = dm_wdata;
                        end
                        default: mem_addr_d = if_addr;
                    endcase
                    if (grant_src == SRC_IF)
                        starve_d = '0;
                    else if (el_if && (starve_q != STARVE_TOP))
                        starve_d = starve_q + 1'b1;
                end
            end
            ACCESS: begin
                if (lat_q == LAT_TOP)
                    state_d = RESP;
                else
                    lat_d = lat_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign if_ack    = (state_q == RESP) && (src_q == SRC_IF);
    assign dm_ack    = (state_q == RESP) && (src_q == SRC_DM);
    assign ld_ack    = (state_q == RESP) && (src_q == SRC_LD);
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign dm_rdata  = dm_ack ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic        contended;

    assign contended = (el_ld & el_dm) | (el_ld & el_if) | (el_dm & el_if);

    always_comb begin
        conflict_d = conflict_q;
        if ((state_q == IDLE) && contended && (conflict_q != 16'hFFFF))
            conflict_d = conflict_q + 16'd1;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) conflict_q <= '0;
        else     conflict_q <= conflict_d;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios followed by randomized rounds
// checked against a transaction-level arbitration and memory model.
module tb_mips_mem_arbiter;

    localparam int AW         = 10;
    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 3;
    localparam int DEPTH      = 1 << AW;

    logic          clk1 = 1'b0;
    logic          rst, halted;
    logic          if_req, dm_req, dm_we, ld_req;
    logic [AW-1:0] if_addr, dm_addr, ld_addr;
    logic [31:0]   dm_wdata, ld_wdata;
    logic          if_ack, dm_ack, ld_ack;
    logic [31:0]   if_rdata, dm_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [15:0]   conflict_cnt;
    logic          mem_init;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          starve_m    = 0;
    int          conflicts_m = 0;
    bit          in_resp     = 1'b0;
    logic [31:0] ref_mem [DEPTH];

    mips_mem_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)   return 32'h28010078;
        if (i == 120) return 32'd85;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory with fixed read latency; non-valid cycles return junk to expose timing slips.
    logic [31:0] mem  [DEPTH];
    logic [31:0] pipe [MEM_LAT];
    always @(posedge clk1) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= mem_en ? mem[mem_addr] : $urandom;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    function automatic int exp_conflicts();
`ifdef MEM_ARB_STATS_EN
        return conflicts_m;
`else
        return 0;
`endif
    endfunction

    // One arbitration using the currently driven requests. Winner ids: 0=IF, 1=DM, 2=LD.
    task automatic run_round(input string tag, input bit drop_halt, output logic [2:0] obs);
        bit          el_ld, el_dm, el_if;
        int          n_el, w, cnt;
        logic [AW-1:0] a;
        logic        w_we;
        logic [31:0] wd;
        obs   = 3'b000;
        el_ld = ld_req && halted;
        el_dm = dm_req;
        el_if = if_req;
        n_el  = int'(el_ld) + int'(el_dm) + int'(el_if);
        if (n_el == 0) begin
            repeat (MEM_LAT + 2) begin
                tick;
                check({tag, "/idle_en"}, 32'(mem_en), 32'd0);
                check({tag, "/idle_ack"}, 32'({ld_ack, dm_ack, if_ack}), 32'd0);
            end
            in_resp = 1'b0;
            return;
        end
        if (el_ld)                                          w = 2;
        else if (el_if && (!el_dm || starve_m == STARVE_MAX)) w = 0;
        else                                                w = 1;
        if (el_if) starve_m = (w == 0) ? 0 : ((starve_m < STARVE_MAX) ? starve_m + 1 : starve_m);
        if (n_el >= 2 && conflicts_m < 65535) conflicts_m++;
        case (w)
            0:       begin a = if_addr; w_we = 1'b0;  wd = 32'd0;    end
            1:       begin a = dm_addr; w_we = dm_we; wd = dm_wdata; end
            default: begin a = ld_addr; w_we = 1'b1;  wd = ld_wdata; end
        endcase

        cnt = 0;
        do begin
            tick;
            cnt++;
        end while (mem_en !== 1'b1 && cnt < 6);
        check({tag, "/grant_wait"}, 32'(cnt), in_resp ? 32'd2 : 32'd1);
        if (mem_en !== 1'b1) begin
            in_resp = 1'b0;
            return;
        end
        check({tag, "/mem_addr"}, 32'(mem_addr), 32'(a));
        check({tag, "/mem_we"}, 32'(mem_we), 32'(w_we));
        check({tag, "/busy_g"}, 32'(busy), 32'd1);
        if (w_we) check({tag, "/mem_wdata"}, mem_wdata, wd);
        if (drop_halt) halted = 1'b0;

        repeat (MEM_LAT - 1) begin
            tick;
            check({tag, "/en_pulse"}, 32'(mem_en), 32'd0);
            check({tag, "/busy_wait"}, 32'(busy), 32'd1);
            check({tag, "/early_ack"}, 32'({ld_ack, dm_ack, if_ack}), 32'd0);
        end
        tick;
        obs = {ld_ack, dm_ack, if_ack};
        check({tag, "/ack"}, 32'(obs), 32'(3'b001 << w));
        check({tag, "/busy_ack"}, 32'(busy), 32'd1);
        check({tag, "/if_rdata"}, if_rdata, (w == 0) ? ref_mem[a] : 32'd0);
        if (w == 1 && !w_we)  check({tag, "/dm_rdata"}, dm_rdata, ref_mem[a]);
        else if (w != 1)      check({tag, "/dm_rdata0"}, dm_rdata, 32'd0);
        if (w_we) ref_mem[a] = wd;
        check({tag, "/conflicts"}, 32'(conflict_cnt), 32'(exp_conflicts()));
        in_resp = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "/mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "/mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "/mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/acks"}, 32'({ld_ack, dm_ack, if_ack}), 32'd0);
        check({tag, "/rdata"}, if_rdata | dm_rdata, 32'd0);
        check({tag, "/conflict"}, 32'(conflict_cnt), 32'd0);
    endtask

    logic [2:0] obs;
    logic [2:0] starve_seq [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
    int         cnt;

    initial begin
        rst = 1'b1; mem_init = 1'b1; halted = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ld_req = 1'b0;
        if_addr = '0; dm_addr = '0; ld_addr = '0; dm_wdata = '0; ld_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        tick;
        check_all_zero("reset");
        tick;
        rst = 1'b0; mem_init = 1'b0;
        tick;

        // Single fetch of word 0
        if_req = 1'b1; if_addr = '0;
        run_round("single_read", 1'b0, obs);
        check("single_read/who", 32'(obs), 32'(3'b001));
        check("single_read/word", if_rdata, 32'h28010078);

        // Data load beats a concurrent fetch; fetch follows back-to-back
        if_addr = AW'(4); dm_req = 1'b1; dm_we = 1'b0; dm_addr = AW'(120);
        run_round("dm_vs_if", 1'b0, obs);
        check("dm_vs_if/who", 32'(obs), 32'(3'b010));
        check("dm_vs_if/data", dm_rdata, 32'd85);
        dm_req = 1'b0;
        run_round("if_after_dm", 1'b0, obs);
        check("if_after_dm/who", 32'(obs), 32'(3'b001));

        // Continuous data traffic: fetch wins on the fourth access
        dm_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dm_addr = AW'(200 + k);
            run_round("starve", 1'b0, obs);
            check("starve/seq", 32'(obs), 32'(starve_seq[k]));
        end

        // Loader ignored while running, then wins over data once halted
        if_req = 1'b0; dm_req = 1'b0;
        ld_req = 1'b1; ld_addr = AW'(7); ld_wdata = 32'hfc000000; halted = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick;
            if (ld_ack || mem_en) cnt++;
        end
        check("ld_gate/no_access", 32'(cnt), 32'd0);
        in_resp = 1'b0;
        halted = 1'b1; dm_req = 1'b1; dm_addr = AW'(9);
        run_round("ld_win", 1'b0, obs);
        check("ld_win/who", 32'(obs), 32'(3'b100));
        ld_req = 1'b0;
        run_round("dm_after_ld", 1'b0, obs);
        dm_req = 1'b0; if_req = 1'b1; if_addr = AW'(7);
        run_round("ld_readback", 1'b0, obs);
        check("ld_readback/word", if_rdata, 32'hfc000000);

        // halted drops during a loader access: still completes
        if_req = 1'b0; ld_req = 1'b1; ld_addr = AW'(11); ld_wdata = 32'h0badf00d;
        run_round("ld_halt_drop", 1'b1, obs);
        check("ld_halt_drop/who", 32'(obs), 32'(3'b100));
        ld_req = 1'b0;

        // Store latency, then reset in the middle of a load
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = AW'(33); dm_wdata = 32'h12345678;
        run_round("store", 1'b0, obs);
        check("store/who", 32'(obs), 32'(3'b010));
        dm_we = 1'b0; dm_addr = AW'(40);
        cnt = 0;
        do begin
            tick;
            cnt++;
        end while (mem_en !== 1'b1 && cnt < 6);
        check("rst_mid/grant", 32'(mem_en), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick;
        dm_req = 1'b0;
        rst = 1'b0;
        starve_m = 0; conflicts_m = 0; in_resp = 1'b0;
        cnt = 0;
        repeat (MEM_LAT + 2) begin
            tick;
            if (dm_ack || if_ack || ld_ack) cnt++;
        end
        check("rst_mid/no_ack", 32'(cnt), 32'd0);
        if_req = 1'b1; if_addr = AW'(120);
        run_round("post_rst", 1'b0, obs);
        check("post_rst/data", if_rdata, 32'd85);

        // Five contended arbitrations from a clean counter
        rst = 1'b1;
        #1;
        rst = 1'b0;
        starve_m = 0; conflicts_m = 0; in_resp = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if_addr = AW'(k); dm_addr = AW'(500 + k);
            run_round("stats", 1'b0, obs);
        end
`ifdef MEM_ARB_STATS_EN
        check("stats/count", 32'(conflict_cnt), 32'd5);
`else
        check("stats/count", 32'(conflict_cnt), 32'd0);
`endif

        // Randomized rounds
        for (int k = 0; k < 200; k++) begin
            if_req   = ($urandom_range(0, 9) < 6);
            dm_req   = ($urandom_range(0, 9) < 6);
            ld_req   = ($urandom_range(0, 9) < 3);
            halted   = ($urandom_range(0, 9) < 5);
            dm_we    = $urandom_range(0, 1);
            if_addr  = AW'($urandom);
            dm_addr  = AW'($urandom);
            ld_addr  = AW'($urandom);
            dm_wdata = $urandom;
            ld_wdata = $urandom;
            run_round("random", ($urandom_range(0, 3) == 0), obs);
        end

        if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
        tick;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
